// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: funct3 encodings, FSM states,
// and the byte-mask, misalignment and legality decoders used at accept time.
// Pure package: no logic, no latency and no backpressure of its own.
package lsu_pkg;

  typedef enum logic [2:0] {
    LSU_B  = 3'b000,
    LSU_H  = 3'b001,
    LSU_W  = 3'b010,
    LSU_BU = 3'b100,
    LSU_HU = 3'b101
  } lsu_funct3_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

  // Byte enables for a store of width funct3 at byte offset off.
  function automatic logic [3:0] wmask_gen(input logic [2:0] funct3, input logic [1:0] off);
    logic [3:0] m;
    case (funct3)
      LSU_B:   m = 4'b0001 << off;
      LSU_H:   m = 4'b0011 << off;
      LSU_W:   m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] off);
    logic bad;
    case (funct3)
      LSU_H, LSU_HU: bad = off[0];
      LSU_W:         bad = (off != 2'b00);
      default:       bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Unsigned widths exist only for loads; anything off the table is illegal.
  function automatic logic illegal(input logic [2:0] funct3, input logic is_store);
    logic bad;
    case (funct3)
      LSU_B, LSU_H, LSU_W: bad = 1'b0;
      LSU_BU, LSU_HU:      bad = is_store;
      default:             bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extracts the addressed byte/half/word lane from a memory word and sign/zero-extends it.
// Latency: purely combinational.
// Backpressure: none.
// Ports: rdata (memory word), off (byte offset), funct3 (width/sign) -> ext (32-bit result).
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] ext
);

  logic [31:0] sh;

  // Bring the addressed byte down to lane 0 before extending.
  assign sh = rdata >> {off, 3'b000};

  always_comb begin
    ext = '0;
    case (funct3)
      LSU_B:   ext = {{24{sh[7]}}, sh[7:0]};
      LSU_H:   ext = {{16{sh[15]}}, sh[15:0]};
      LSU_W:   ext = rdata;
      LSU_BU:  ext = {24'b0, sh[7:0]};
      LSU_HU:  ext = {16'b0, sh[15:0]};
      default: ext = '0;
    endcase
  end

endmodule

// File: rtl/lsu_dmem_ctrl.sv
// Blocking load/store unit between EXU and the RAM data port: one op in flight.
// Latency: accept at edge N, memory access in cycle N+1, response in N+2 (N+1 on error).
// Backpressure: req_ready only in IDLE; resp_ready low holds RESP with outputs stable.
// Ports: req_* (EXU request, valid/ready), resp_* (WBU result, valid/ready),
//        dmem_* (word-aligned RAM port: addr, wdata, wen, wmask out; rdata in, combinational).
// Only XLEN = 32 is supported.
module lsu_dmem_ctrl
  import lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [REG_AW-1:0] req_rd,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic [REG_AW-1:0] resp_rd,
  output logic              resp_is_load,
  output logic              resp_err,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic              dmem_wen,
  output logic [3:0]        dmem_wmask,
  input  logic [XLEN-1:0]   dmem_rdata
);

  lsu_state_e      state, state_nxt;
  logic [XLEN-1:0] addr_q, wdata_q;
  logic [2:0]      funct3_q;
  logic            is_store_q;
  logic [1:0]      off;
  logic [XLEN-1:0] load_ext;
  logic            req_fire;
  logic            req_bad;

  assign off      = addr_q[1:0];
  assign req_fire = req_valid && req_ready;
  assign req_bad  = illegal(req_funct3, req_is_store) || misaligned(req_funct3, req_addr[1:0]);

  // Address and data come from the op registers so the RAM sees stable values in every state.
  assign dmem_addr  = {addr_q[XLEN-1:2], 2'b00};
  assign dmem_wdata = wdata_q << {off, 3'b000};

  lsu_load_align u_load_align (
    .rdata  (dmem_rdata),
    .off    (off),
    .funct3 (funct3_q),
    .ext    (load_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Strobes are decoded from state, so an async reset during ACCESS drops dmem_wen at once.
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    dmem_wen   = 1'b0;
    dmem_wmask = 4'b0000;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = req_bad ? ST_RESP : ST_ACCESS;
      end
      ST_ACCESS: begin
        dmem_wen   = is_store_q;
        dmem_wmask = is_store_q ? wmask_gen(funct3_q, off) : 4'b0000;
        state_nxt  = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      funct3_q     <= 3'b000;
      is_store_q   <= 1'b0;
      resp_rd      <= '0;
      resp_is_load <= 1'b0;
      resp_err     <= 1'b0;
      resp_rdata   <= '0;
    end else if (req_fire) begin
      addr_q       <= req_addr;
      wdata_q      <= req_wdata;
      funct3_q     <= req_funct3;
      is_store_q   <= req_is_store;
      resp_rd      <= req_rd;
      resp_is_load <= !req_is_store;
      resp_err     <= req_bad;
      // Stores and rejected ops report zero; loads overwrite this during ACCESS.
      resp_rdata   <= '0;
    end else if (state == ST_ACCESS && !is_store_q) begin
      resp_rdata   <= load_ext;
    end
  end

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
module tb_lsu_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [4:0]  req_rd = 5'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic        resp_is_load;
  logic        resp_err;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_wen;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_dmem_ctrl #(.XLEN(32), .REG_AW(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_is_store (req_is_store),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_rd       (req_rd),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_rd      (resp_rd),
    .resp_is_load (resp_is_load),
    .resp_err     (resp_err),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_wen     (dmem_wen),
    .dmem_wmask   (dmem_wmask),
    .dmem_rdata   (dmem_rdata)
  );

  // Memory model: 64 words, combinational read, masked write on posedge.
  logic [31:0] mem [0:63];
  logic        mem_inited = 1'b0;
  logic [31:0] wword;

  assign dmem_rdata = mem[dmem_addr[7:2]];

  always @(posedge clk) begin
    if (!mem_inited) begin
      for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 | i;
      mem[8] = 32'h80FF_7F01;
      mem_inited = 1'b1;
    end else if (dmem_wen) begin
      wword = mem[dmem_addr[7:2]];
      for (int i = 0; i < 4; i++)
        if (dmem_wmask[i]) wword[8*i +: 8] = dmem_wdata[8*i +: 8];
      mem[dmem_addr[7:2]] = wword;
    end
  end

  // Observer: an ACCESS cycle is one where neither handshake side is open.
  int          acc_cnt = 0;
  int          wen_cnt = 0;
  int          stray_cnt = 0;
  logic [31:0] acc_addr = 32'h0;
  logic [31:0] acc_wdata = 32'h0;
  logic [3:0]  acc_mask = 4'h0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (!req_ready && !resp_valid) begin
        acc_cnt++;
        acc_addr  = dmem_addr;
        acc_mask  = dmem_wmask;
        acc_wdata = dmem_wdata;
      end
      if (dmem_wen) wen_cnt++;
      if ((dmem_wen || dmem_wmask != 4'h0) && (req_ready || resp_valid)) stray_cnt++;
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        is_load;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp_v);
    end
  endtask

  task automatic do_op(input string name, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                       input logic [31:0] exp_rdata, input logic exp_err, input int hold);
    exp_t e;
    exp_t got;
    int   lat;
    int   acc0;
    int   wen0;
    e.rdata   = exp_rdata;
    e.rd      = rd;
    e.is_load = ~st;
    e.err     = exp_err;
    e.lat     = exp_err ? 1 : 2;
    @(negedge clk);
    acc0 = acc_cnt;
    wen0 = wen_cnt;
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
    req_addr = a; req_wdata = wd; req_rd = rd;
    sb.push_back(e);
    chk({name, "_req_ready_idle"}, 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      chk({name, "_req_ready_busy"}, 32'(req_ready), 32'd0);
      @(negedge clk);
      lat++;
    end
    chk({name, "_resp_valid"}, 32'(resp_valid), 32'd1);
    chk({name, "_latency"}, lat, e.lat);
    for (int i = 0; i < hold; i++) begin
      chk({name, "_hold_valid"}, 32'(resp_valid), 32'd1);
      chk({name, "_hold_rdata"}, resp_rdata, e.rdata);
      chk({name, "_hold_rd"}, 32'(resp_rd), 32'(e.rd));
      chk({name, "_hold_req_ready"}, 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    got = sb.pop_front();
    chk({name, "_rdata"}, resp_rdata, got.rdata);
    chk({name, "_rd"}, 32'(resp_rd), 32'(got.rd));
    chk({name, "_is_load"}, 32'(resp_is_load), 32'(got.is_load));
    chk({name, "_err"}, 32'(resp_err), 32'(got.err));
    chk({name, "_access_cycles"}, acc_cnt - acc0, got.err ? 32'd0 : 32'd1);
    chk({name, "_wen_cycles"}, wen_cnt - wen0, (st && !got.err) ? 32'd1 : 32'd0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk({name, "_post_valid"}, 32'(resp_valid), 32'd0);
    chk({name, "_post_req_ready"}, 32'(req_ready), 32'd1);
  endtask

  task automatic chk_zero_outputs(input string name);
    chk({name, "_wen"}, 32'(dmem_wen), 32'd0);
    chk({name, "_wmask"}, 32'(dmem_wmask), 32'd0);
    chk({name, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({name, "_resp_rdata"}, resp_rdata, 32'd0);
    chk({name, "_resp_rd"}, 32'(resp_rd), 32'd0);
    chk({name, "_resp_err"}, 32'(resp_err), 32'd0);
    chk({name, "_resp_is_load"}, 32'(resp_is_load), 32'd0);
    chk({name, "_dmem_addr"}, dmem_addr, 32'd0);
    chk({name, "_dmem_wdata"}, dmem_wdata, 32'd0);
    chk({name, "_req_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("after_reset_wen", 32'(dmem_wen), 32'd0);
    chk("after_reset_valid", 32'(resp_valid), 32'd0);

    // Word store, then byte/half stores merged into the same word.
    do_op("sw", 1'b1, 3'b010, 32'h8000_0010, 32'hDEAD_BEEF, 5'd1, 32'h0, 1'b0, 0);
    chk("sw_addr", acc_addr, 32'h8000_0010);
    chk("sw_mask", 32'(acc_mask), 32'hF);
    chk("sw_wdata", acc_wdata, 32'hDEAD_BEEF);
    do_op("sb3", 1'b1, 3'b000, 32'h8000_0013, 32'h0000_00A5, 5'd2, 32'h0, 1'b0, 0);
    chk("sb3_addr", acc_addr, 32'h8000_0010);
    chk("sb3_mask", 32'(acc_mask), 32'h8);
    chk("sb3_wdata", acc_wdata, 32'hA500_0000);
    do_op("lw_rb1", 1'b0, 3'b010, 32'h8000_0010, 32'h0, 5'd3, 32'hA5AD_BEEF, 1'b0, 0);
    chk("lw_rb1_mask", 32'(acc_mask), 32'h0);
    do_op("sh2", 1'b1, 3'b001, 32'h8000_0012, 32'hCAFE_1234, 5'd4, 32'h0, 1'b0, 0);
    chk("sh2_mask", 32'(acc_mask), 32'hC);
    chk("sh2_wdata", acc_wdata, 32'h1234_0000);
    do_op("sb1", 1'b1, 3'b000, 32'h8000_0011, 32'h0000_0077, 5'd5, 32'h0, 1'b0, 0);
    chk("sb1_mask", 32'(acc_mask), 32'h2);
    chk("sb1_wdata", acc_wdata, 32'h0000_7700);
    do_op("lw_rb2", 1'b0, 3'b010, 32'h8000_0010, 32'h0, 5'd6, 32'h1234_77EF, 1'b0, 0);

    // Load extraction from 0x80FF_7F01.
    do_op("lb0", 1'b0, 3'b000, 32'h8000_0020, 32'h0, 5'd7, 32'h0000_0001, 1'b0, 0);
    chk("lb0_addr", acc_addr, 32'h8000_0020);
    do_op("lb2", 1'b0, 3'b000, 32'h8000_0022, 32'h0, 5'd8, 32'hFFFF_FFFF, 1'b0, 0);
    chk("lb2_addr", acc_addr, 32'h8000_0020);
    do_op("lbu3", 1'b0, 3'b100, 32'h8000_0023, 32'h0, 5'd9, 32'h0000_0080, 1'b0, 0);
    do_op("lh2", 1'b0, 3'b001, 32'h8000_0022, 32'h0, 5'd10, 32'hFFFF_80FF, 1'b0, 0);
    do_op("lhu0", 1'b0, 3'b101, 32'h8000_0020, 32'h0, 5'd11, 32'h0000_7F01, 1'b0, 0);
    do_op("lhu2", 1'b0, 3'b101, 32'h8000_0022, 32'h0, 5'd12, 32'h0000_80FF, 1'b0, 0);

    // Misaligned and illegal ops: no access, response one cycle after accept.
    do_op("lw_mis", 1'b0, 3'b010, 32'h8000_0002, 32'h0, 5'd13, 32'h0, 1'b1, 0);
    do_op("sh_mis", 1'b1, 3'b001, 32'h8000_0001, 32'h1111_2222, 5'd14, 32'h0, 1'b1, 0);
    do_op("lh_mis", 1'b0, 3'b001, 32'h8000_0023, 32'h0, 5'd15, 32'h0, 1'b1, 0);
    do_op("sbu_ill", 1'b1, 3'b100, 32'h8000_0000, 32'h0000_0055, 5'd16, 32'h0, 1'b1, 0);
    do_op("f3_ill", 1'b0, 3'b011, 32'h8000_0020, 32'h0, 5'd17, 32'h0, 1'b1, 0);
    chk("mem_untouched_by_err", mem[0], 32'hC0DE_0000);

    // Response backpressure: held five cycles.
    do_op("lw_hold", 1'b0, 3'b010, 32'h8000_0020, 32'h0, 5'd18, 32'h80FF_7F01, 1'b0, 5);

    // Reset asserted in the middle of an ACCESS cycle of a word store.
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h8000_0030; req_wdata = 32'h1234_5678; req_rd = 5'd19;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_mid_pre_wen", 32'(dmem_wen), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("rst_mid");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mid_no_write", mem[12], 32'hC0DE_000C);
    do_op("sw_after_rst", 1'b1, 3'b010, 32'h8000_0030, 32'h1234_5678, 5'd20, 32'h0, 1'b0, 0);
    do_op("lw_after_rst", 1'b0, 3'b010, 32'h8000_0030, 32'h0, 5'd21, 32'h1234_5678, 1'b0, 0);

    chk("no_stray_strobes", stray_cnt, 32'd0);
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
